// File: rtl/bus_mem_target.sv
// bus_mem_target: single-word read/write target on the shared FRAME_B/IRDY_B/TRDY_B/AD bus.
module bus_mem_target #(
  parameter logic [31:0] BASE_ADDR   = 32'h200,
  parameter int          DEPTH       = 64,
  parameter int          WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        RST_B,
  inout  wire  [31:0] AD,
  input  logic        FRAME_B,
  input  logic        CMD,
  input  logic        IRDY_B,
  output logic        TRDY_B,
  output logic        WR_STB,
  output logic [31:0] WR_ADDR,
  output logic [31:0] WR_DATA
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(DEPTH - 1);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_DONE} state_t;
  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   addr_q, rdata_q, wr_addr_q, wr_data_q;
  logic          wr_q, rd_oe_q, trdy_oe_q, trdy_q, wr_stb_q;
  logic [31:0]   mem_q [DEPTH];
  logic          hit, start;
  assign hit   = (AD >= BASE_ADDR) && (AD <= LAST_ADDR);
  // FRAME_B may stay low between transactions, so IRDY_B inactive marks the address phase
  assign start = (FRAME_B == 1'b0) && (IRDY_B != 1'b0) && hit;
  assign AD      = rd_oe_q ? rdata_q : 'z;
  assign TRDY_B  = trdy_oe_q ? trdy_q : 1'bz;
  assign WR_STB  = wr_stb_q;
  assign WR_ADDR = wr_addr_q;
  assign WR_DATA = wr_data_q;
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      rdata_q   <= '0;
      wr_q      <= 1'b0;
      rd_oe_q   <= 1'b0;
      trdy_oe_q <= 1'b0;
      trdy_q    <= 1'b1;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_stb_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          rd_oe_q   <= 1'b0;
          trdy_oe_q <= 1'b0;
          trdy_q    <= 1'b1;
          state_q   <= S_IDLE;
          if (start) begin
            state_q   <= S_WAIT;
            cnt_q     <= 4'(WAIT_STATES);
            idx_q     <= AD[AW-1:0];
            addr_q    <= AD;
            wr_q      <= CMD;
            trdy_oe_q <= 1'b1;
          end
        end
        S_WAIT: begin
          rdata_q <= mem_q[idx_q];
          rd_oe_q <= !wr_q;
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
          else if (IRDY_B == 1'b0) begin
            state_q <= S_XFER;
            trdy_q  <= 1'b0;
            if (wr_q) begin
              mem_q[idx_q] <= AD;
              wr_stb_q     <= 1'b1;
              wr_addr_q    <= addr_q;
              wr_data_q    <= AD;
            end
          end
        end
        S_XFER: begin
          state_q <= S_DONE;
          trdy_q  <= 1'b1;
          rd_oe_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
